// File: rtl/e203_ifu_bhtbpu.sv
// IFU branch predictor: BHT of saturating counters for Bxx, always-taken JAL/JALR,
// optional return-address stack enabled by E203_BPU_RAS_EN.
module e203_ifu_bhtbpu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc,
    input  logic            dec_i_valid,
    input  logic            dec_bxx,
    input  logic            dec_jal,
    input  logic            dec_jalr,
    input  logic            dec_rvc,
    input  logic [XLEN-1:0] dec_bjp_imm,
    input  logic [4:0]      dec_rs1idx,
    input  logic [4:0]      dec_rdidx,
    input  logic            jalr_dep,
    input  logic [XLEN-1:0] rf2bpu_x1,
    input  logic [XLEN-1:0] rf2bpu_rs1,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            ras_flush,
    output logic            prdt_taken,
    output logic [PC_W-1:0] prdt_pc_add_op1,
    output logic [PC_W-1:0] prdt_pc_add_op2,
    output logic            bpu_wait
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] bht [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] up_idx;
    logic             rs1_x0;
    logic             rs1_x1;
    logic             ras_hit;
    logic [PC_W-1:0]  ras_top;

    assign rd_idx = pc[IDX_W:1];
    assign up_idx = upd_pc[IDX_W:1];
    assign rs1_x0 = (dec_rs1idx == 5'd0);
    assign rs1_x1 = (dec_rs1idx == 5'd1);

    // Counter training; a same-cycle lookup reads the pre-update value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken && (bht[up_idx] != CNT_MAX)) begin
                bht[up_idx] <= bht[up_idx] + CNT_W'(1);
            end else if (!upd_taken && (bht[up_idx] != '0)) begin
                bht[up_idx] <= bht[up_idx] - CNT_W'(1);
            end
        end
    end

`ifdef E203_BPU_RAS_EN
    localparam int unsigned RP_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [RP_W-1:0] ras_wp;
    logic [RP_W:0]   ras_cnt;
    logic [RP_W-1:0] ras_wr_ptr;
    logic            rd_x1;
    logic            is_call;
    logic            is_ret;
    logic            ras_fire;
    logic            ras_push;
    logic            ras_pop;
    logic [PC_W-1:0] ras_link;

    assign rd_x1      = (dec_rdidx == 5'd1);
    assign is_call    = (dec_jal | dec_jalr) & rd_x1;
    assign is_ret     = dec_jalr & rs1_x1 & ~rd_x1;
    assign ras_hit    = is_ret & (ras_cnt != '0);
    assign ras_top    = ras[ras_wp - RP_W'(1)];
    assign ras_fire   = dec_i_valid & ~bpu_wait;
    assign ras_push   = ras_fire & is_call;
    // Coroutine (call with rs1=x1) pops then pushes, replacing the top in place.
    assign ras_pop    = ras_fire & dec_jalr & rs1_x1 & (ras_cnt != '0);
    assign ras_wr_ptr = ras_pop ? (ras_wp - RP_W'(1)) : ras_wp;
    assign ras_link   = pc + (dec_rvc ? PC_W'(2) : PC_W'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
        end else if (ras_flush) begin
            ras_cnt <= '0;
        end else begin
            if (ras_push) begin
                ras_wp <= ras_wr_ptr + RP_W'(1);
            end else if (ras_pop) begin
                ras_wp <= ras_wp - RP_W'(1);
            end
            if (ras_push && !ras_pop && (ras_cnt != (RP_W + 1)'(RAS_DEPTH))) begin
                ras_cnt <= ras_cnt + (RP_W + 1)'(1);
            end else if (ras_pop && !ras_push) begin
                ras_cnt <= ras_cnt - (RP_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ras_push && !ras_flush) begin
            ras[ras_wr_ptr] <= ras_link;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{upd_pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1};
`else
    assign ras_hit = 1'b0;
    assign ras_top = '0;

    logic unused_ok;
    assign unused_ok = ^{upd_pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1,
                         dec_rdidx, ras_flush, dec_rvc, ras_top};
`endif

    // Next-PC adder operand selection.
    always_comb begin
        prdt_pc_add_op1 = pc;
        prdt_pc_add_op2 = dec_bjp_imm[PC_W-1:0];
        if (dec_jalr) begin
            if (rs1_x0) begin
                prdt_pc_add_op1 = '0;
            end else if (ras_hit) begin
                prdt_pc_add_op1 = ras_top;
                prdt_pc_add_op2 = '0;
            end else if (rs1_x1) begin
                prdt_pc_add_op1 = rf2bpu_x1[PC_W-1:0];
            end else begin
                prdt_pc_add_op1 = rf2bpu_rs1[PC_W-1:0];
            end
        end
    end

    assign prdt_taken = dec_i_valid & ((dec_bxx & bht[rd_idx][CNT_W-1]) | dec_jal | dec_jalr);
    assign bpu_wait   = dec_i_valid & dec_jalr & ~rs1_x0 & jalr_dep & ~ras_hit;

endmodule

// File: tb/tb_e203_ifu_bhtbpu.sv
// Directed bench for e203_ifu_bhtbpu: expected outputs queued per step, popped and checked mid-cycle.
module tb_e203_ifu_bhtbpu;

`ifdef E203_BPU_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam logic [31:0] X1V  = 32'hDEAD_0000;
    localparam logic [31:0] RS1V = 32'hBEEF_0040;
    localparam logic [31:0] RIMM = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        dec_i_valid, dec_bxx, dec_jal, dec_jalr, dec_rvc;
    logic [31:0] dec_bjp_imm;
    logic [4:0]  dec_rs1idx, dec_rdidx;
    logic        jalr_dep;
    logic [31:0] rf2bpu_x1, rf2bpu_rs1;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken, ras_flush;
    logic        prdt_taken;
    logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
    logic        bpu_wait;

    typedef struct {
        string       tag;
        logic        taken;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        wt;
        bit          ops;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    e203_ifu_bhtbpu dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .dec_i_valid(dec_i_valid),
        .dec_bxx(dec_bxx), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_rvc(dec_rvc),
        .dec_bjp_imm(dec_bjp_imm), .dec_rs1idx(dec_rs1idx), .dec_rdidx(dec_rdidx),
        .jalr_dep(jalr_dep), .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .ras_flush(ras_flush),
        .prdt_taken(prdt_taken), .prdt_pc_add_op1(prdt_pc_add_op1),
        .prdt_pc_add_op2(prdt_pc_add_op2), .bpu_wait(bpu_wait)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic t, input logic [31:0] o1,
                            input logic [31:0] o2, input logic w, input bit ops);
        exp_t e;
        e.tag = tag; e.taken = t; e.op1 = o1; e.op2 = o2; e.wt = w; e.ops = ops;
        sb.push_back(e);
    endtask

    // Settle combinational outputs, then pop one expectation and compare.
    task automatic check_out();
        exp_t e;
        #3;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".taken"}, 32'(prdt_taken), 32'(e.taken));
            cmp({e.tag, ".wait"}, 32'(bpu_wait), 32'(e.wt));
            if (e.ops) begin
                cmp({e.tag, ".op1"}, prdt_pc_add_op1, e.op1);
                cmp({e.tag, ".op2"}, prdt_pc_add_op2, e.op2);
            end
        end
    endtask

    task automatic clr();
        pc = '0; dec_i_valid = 0; dec_bxx = 0; dec_jal = 0; dec_jalr = 0; dec_rvc = 0;
        dec_bjp_imm = '0; dec_rs1idx = '0; dec_rdidx = '0; jalr_dep = 0;
        rf2bpu_x1 = X1V; rf2bpu_rs1 = RS1V;
        upd_valid = 0; upd_pc = '0; upd_taken = 0; ras_flush = 0;
    endtask

    task automatic bxx(input string tag, input logic [31:0] p, input logic t);
        @(negedge clk); clr();
        dec_i_valid = 1; dec_bxx = 1; pc = p; dec_bjp_imm = 32'h40;
        push_exp(tag, t, p, 32'h40, 1'b0, 1'b1);
        check_out();
    endtask

    task automatic train(input string tag, input logic [31:0] p, input logic t);
        @(negedge clk); clr();
        upd_valid = 1; upd_pc = p; upd_taken = t;
        push_exp(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out();
    endtask

    task automatic call(input string tag, input logic [31:0] p, input logic rvc);
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jal = 1; dec_rdidx = 5'd1; dec_rvc = rvc; pc = p;
        dec_bjp_imm = 32'h100;
        push_exp(tag, 1'b1, p, 32'h100, 1'b0, 1'b1);
        check_out();
    endtask

    // JALR x0, RIMM(x1); hit says whether the RAS should supply the target.
    task automatic ret(input string tag, input logic dep, input bit hit, input logic [31:0] top);
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jalr = 1; dec_rs1idx = 5'd1; dec_rdidx = 5'd0;
        pc = 32'h0000_9000; dec_bjp_imm = RIMM; jalr_dep = dep;
        if (RAS_ON && hit) push_exp(tag, 1'b1, top, 32'h0, 1'b0, 1'b1);
        else               push_exp(tag, 1'b1, X1V, RIMM, dep, 1'b1);
        check_out();
    endtask

    initial begin
        clr();
        rst_n = 0;
        dec_i_valid = 0; dec_bxx = 1; pc = 32'h100;
        push_exp("in_reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out();
        #12 rst_n = 1;

        bxx("bxx_reset_wnt", 32'h100, 1'b0);
        train("trn1", 32'h100, 1'b1);
        train("trn2", 32'h100, 1'b1);
        bxx("bxx_after_2t", 32'h100, 1'b1);
        train("trn3", 32'h100, 1'b1);
        train("trn4", 32'h100, 1'b1);
        train("trn_nt1", 32'h100, 1'b0);
        bxx("bxx_sat_nt1", 32'h100, 1'b1);
        train("trn_nt2", 32'h100, 1'b0);
        bxx("bxx_nt2", 32'h100, 1'b0);

        // Lookup and update on the same index in one cycle: lookup sees old value.
        @(negedge clk); clr();
        dec_i_valid = 1; dec_bxx = 1; pc = 32'h100; dec_bjp_imm = 32'h40;
        upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
        push_exp("no_bypass", 1'b0, 32'h100, 32'h40, 1'b0, 1'b1);
        check_out();
        bxx("after_bypass", 32'h100, 1'b1);

        bxx("alias_read", 32'h180, 1'b1);
        train("alias_t1", 32'h180, 1'b0);
        train("alias_t2", 32'h180, 1'b0);
        bxx("alias_effect", 32'h100, 1'b0);
        bxx("other_idx", 32'h104, 1'b0);
        train("other_trn", 32'h104, 1'b1);
        bxx("other_taken", 32'h104, 1'b1);
        bxx("alias_kept", 32'h100, 1'b0);

        @(negedge clk); clr();
        dec_bxx = 1; pc = 32'h104;
        push_exp("invalid_dec", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_out();

        @(negedge clk); clr();
        dec_i_valid = 1; dec_jal = 1; dec_rdidx = 5'd5; pc = 32'h400; dec_bjp_imm = 32'hFFFF_FFF0;
        push_exp("jal_plain", 1'b1, 32'h400, 32'hFFFF_FFF0, 1'b0, 1'b1);
        check_out();
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jalr = 1; dec_rs1idx = 5'd0; jalr_dep = 1; dec_bjp_imm = 32'h80;
        push_exp("jalr_x0", 1'b1, 32'h0, 32'h80, 1'b0, 1'b1);
        check_out();
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jalr = 1; dec_rs1idx = 5'd7; jalr_dep = 1; dec_bjp_imm = 32'h8;
        push_exp("jalr_xn_dep", 1'b1, RS1V, 32'h8, 1'b1, 1'b1);
        check_out();
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jalr = 1; dec_rs1idx = 5'd7; dec_bjp_imm = 32'h8;
        push_exp("jalr_xn_rdy", 1'b1, RS1V, 32'h8, 1'b0, 1'b1);
        check_out();

        call("call_200", 32'h200, 1'b0);
        ret("ret_204", 1'b1, 1'b1, 32'h204);
        call("call_rvc_300", 32'h300, 1'b1);
        ret("ret_302", 1'b1, 1'b1, 32'h302);

        for (int i = 0; i < 5; i++) call($sformatf("fill%0d", i), 32'h1000 + 32'(i * 16), 1'b0);
        for (int i = 0; i < 4; i++) ret($sformatf("lifo%0d", i), 1'b1, 1'b1, 32'h1044 - 32'(i * 16));
        ret("ret_empty_dep", 1'b1, 1'b0, 32'h0);
        ret("ret_empty_rdy", 1'b0, 1'b0, 32'h0);

        call("call_600", 32'h600, 1'b0);
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jal = 1; dec_rdidx = 5'd1; pc = 32'h500; dec_bjp_imm = 32'h100;
        ras_flush = 1; upd_valid = 1; upd_pc = 32'h104; upd_taken = 0;
        push_exp("flush_call", 1'b1, 32'h500, 32'h100, 1'b0, 1'b1);
        check_out();
        ret("ret_after_flush", 1'b1, 1'b0, 32'h0);
        bxx("bht_flush_cycle", 32'h104, 1'b0);

        call("call_700", 32'h700, 1'b0);
        @(negedge clk); clr();
        dec_i_valid = 1; dec_jalr = 1; dec_rs1idx = 5'd1; dec_rdidx = 5'd1; pc = 32'h800;
        dec_bjp_imm = 32'h20;
        push_exp("coroutine", 1'b1, X1V, 32'h20, 1'b0, 1'b1);
        check_out();
        ret("ret_co_804", 1'b1, 1'b1, 32'h804);
        ret("ret_co_empty", 1'b1, 1'b0, 32'h0);

        train("pre_rst_trn", 32'h104, 1'b1);
        bxx("pre_rst_taken", 32'h104, 1'b1);
        call("pre_rst_call", 32'hA00, 1'b0);
        @(negedge clk); clr();
        #2 rst_n = 0;
        #2 rst_n = 1;
        ret("post_rst_ras", 1'b1, 1'b0, 32'h0);
        bxx("post_rst_bht", 32'h104, 1'b0);

        @(negedge clk); clr();
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
